// File: rtl/mips_decode_pkg.sv
// mips_decode_pkg: shared decode definitions for decode_stage_hs.
//   - MIPS opcode / funct encodings, HALT sentinel word
//   - control-bundle bit layout and field encodings
//   - FSM state type
//   - decode_ctrl(): opcode/funct -> control bundle (unknown opcode -> all zero)
package mips_decode_pkg;

  localparam int unsigned CTRL_W = 14;

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // Control-bundle bit positions (two-bit fields start at the given index)
  localparam int unsigned CB_REG_WRITE = 0;
  localparam int unsigned CB_MEM_READ  = 1;
  localparam int unsigned CB_MEM_WRITE = 2;
  localparam int unsigned CB_MEM2REG   = 3;
  localparam int unsigned CB_REG_DST   = 4;
  localparam int unsigned CB_BRANCH    = 5;
  localparam int unsigned CB_JUMP      = 6;
  localparam int unsigned CB_ALU_SRC   = 7;
  localparam int unsigned CB_ALU_OP    = 9;
  localparam int unsigned CB_WIDTH     = 11;
  localparam int unsigned CB_SIGN      = 13;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] SRC_REG   = 2'b00;
  localparam logic [1:0] SRC_IMM   = 2'b01;

  localparam logic [1:0] W_BYTE    = 2'b00;
  localparam logic [1:0] W_HALF    = 2'b01;
  localparam logic [1:0] W_WORD    = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } dec_state_t;

  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [5:0] opcode,
                                                    input logic [5:0] funct);
    logic [CTRL_W-1:0] c;
    c = '0;
    case (opcode)
      OP_R_TYPE: begin
        if (funct == FN_JR) begin
          c[CB_JUMP] = 1'b1;
        end else if (funct == FN_JALR) begin
          c[CB_JUMP]      = 1'b1;
          c[CB_REG_WRITE] = 1'b1;
          c[CB_REG_DST]   = 1'b1;
          c[CB_ALU_OP +: 2] = ALU_ADD;
        end else begin
          c[CB_REG_WRITE] = 1'b1;
          c[CB_REG_DST]   = 1'b1;
          c[CB_ALU_OP +: 2] = ALU_RTYPE;
        end
      end
      OP_J: c[CB_JUMP] = 1'b1;
      OP_JAL: begin
        c[CB_JUMP]      = 1'b1;
        c[CB_REG_WRITE] = 1'b1;
        c[CB_REG_DST]   = 1'b1;
        c[CB_ALU_OP +: 2] = ALU_ADD;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        c[CB_BRANCH] = 1'b1;
        c[CB_ALU_OP +: 2] = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        c[CB_REG_WRITE] = 1'b1;
        c[CB_ALU_SRC +: 2] = SRC_IMM;
        c[CB_ALU_OP +: 2]  = ALU_IMM;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        c[CB_REG_WRITE] = 1'b1;
        c[CB_MEM_READ]  = 1'b1;
        c[CB_MEM2REG]   = 1'b1;
        c[CB_ALU_SRC +: 2] = SRC_IMM;
        c[CB_WIDTH +: 2]   = (opcode == OP_LW) ? W_WORD :
                             ((opcode == OP_LH || opcode == OP_LHU) ? W_HALF : W_BYTE);
        c[CB_SIGN] = (opcode == OP_LB || opcode == OP_LH || opcode == OP_LW);
      end
      OP_SB, OP_SH, OP_SW: begin
        c[CB_MEM_WRITE] = 1'b1;
        c[CB_ALU_SRC +: 2] = SRC_IMM;
        c[CB_WIDTH +: 2]   = (opcode == OP_SW) ? W_WORD :
                             ((opcode == OP_SH) ? W_HALF : W_BYTE);
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_hs_regfile.sv
// regfile_bypass: register file with two asynchronous read ports and one
// synchronous write port; a same-cycle write is bypassed to the readers.
//   clk, i_rst               clock, synchronous active-high reset (clears all regs)
//   i_we/i_waddr/i_wdata     write port ($0 never written)
//   i_raddr_a/b, o_rdata_a/b asynchronous reads, $0 reads zero
module regfile_bypass #(
  parameter  int NB_DATA = 32,
  parameter  int NB_REGS = 32,
  localparam int NB_ADDR = $clog2(NB_REGS)
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic [NB_ADDR-1:0] i_raddr_a,
  input  logic [NB_ADDR-1:0] i_raddr_b,
  output logic [NB_DATA-1:0] o_rdata_a,
  output logic [NB_DATA-1:0] o_rdata_b
);

  logic [NB_DATA-1:0] mem [NB_REGS];

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NB_REGS; i++) mem[i] <= '0;
    end else if (i_we && i_waddr != '0) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata_a = mem[i_raddr_a];
    if (i_raddr_a == '0)                        o_rdata_a = '0;
    else if (i_we && i_waddr == i_raddr_a)      o_rdata_a = i_wdata;
  end

  always_comb begin
    o_rdata_b = mem[i_raddr_b];
    if (i_raddr_b == '0)                        o_rdata_b = '0;
    else if (i_we && i_waddr == i_raddr_b)      o_rdata_b = i_wdata;
  end

endmodule

// File: rtl/decode_stage_hs.sv
// decode_stage_hs: MIPS instruction-decode stage with valid/ready handshake.
//   Inputs : fetch side (i_valid, i_instruction, i_pcounter4), i_flush,
//            write-back port (i_wb_*), EX forward (i_ex_*), i_ready from execute.
//   Outputs: o_ready to fetch, ID/EX register (o_valid, o_rs/rt/rd, o_reg_a/b,
//            o_immediate, o_opcode/func/shamt, o_ctrl), branch redirect pulse,
//            o_halted after a HALT word has drained.
// Branches and jumps resolve here using EX > WB > regfile operand priority.
module decode_stage_hs
  import mips_decode_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_REGS = 32,
  parameter int NB_ADDR = $clog2(NB_REGS),
  parameter int NB_CTRL = 14
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [31:0]        i_instruction,
  input  logic [NB_DATA-1:0] i_pcounter4,
  input  logic               i_flush,
  input  logic               i_wb_we,
  input  logic [NB_ADDR-1:0] i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data,
  input  logic               i_ex_we,
  input  logic [NB_ADDR-1:0] i_ex_addr,
  input  logic [NB_DATA-1:0] i_ex_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_ADDR-1:0] o_rs,
  output logic [NB_ADDR-1:0] o_rt,
  output logic [NB_ADDR-1:0] o_rd,
  output logic [NB_DATA-1:0] o_reg_a,
  output logic [NB_DATA-1:0] o_reg_b,
  output logic [NB_DATA-1:0] o_immediate,
  output logic [5:0]         o_opcode,
  output logic [5:0]         o_func,
  output logic [4:0]         o_shamt,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic               o_redirect,
  output logic [NB_DATA-1:0] o_redirect_addr,
  output logic               o_halted
);

  dec_state_t state, state_next;
  logic run;

  logic [5:0]         in_op, in_fn;
  logic [NB_ADDR-1:0] in_rs, in_rt, in_rd, ex_dest;
  logic [CTRL_W-1:0]  in_ctrl;
  logic               is_halt, is_branch, is_jr, is_jalr, is_link;
  logic [NB_DATA-1:0] rf_a, rf_b, br_a, br_b;
  logic [NB_DATA-1:0] imm_sext, imm_ext, btarget, jtarget, target;
  logic               taken, load_use, br_hazard, hazard, accept;

  assign in_op   = i_instruction[31:26];
  assign in_fn   = i_instruction[5:0];
  assign in_rs   = NB_ADDR'(i_instruction[25:21]);
  assign in_rt   = NB_ADDR'(i_instruction[20:16]);
  assign in_rd   = NB_ADDR'(i_instruction[15:11]);
  assign in_ctrl = decode_ctrl(in_op, in_fn);

  assign is_halt   = (i_instruction == HALT_WORD);
  assign is_branch = (in_op == OP_BEQ) || (in_op == OP_BNE) ||
                     (in_op == OP_BLEZ) || (in_op == OP_BGTZ);
  assign is_jr     = (in_op == OP_R_TYPE) && (in_fn == FN_JR || in_fn == FN_JALR);
  assign is_jalr   = (in_op == OP_R_TYPE) && (in_fn == FN_JALR);
  assign is_link   = (in_op == OP_JAL) || is_jalr;

  regfile_bypass #(
    .NB_DATA (NB_DATA),
    .NB_REGS (NB_REGS)
  ) u_regfile (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_we      (i_wb_we),
    .i_waddr   (i_wb_addr),
    .i_wdata   (i_wb_data),
    .i_raddr_a (in_rs),
    .i_raddr_b (in_rt),
    .o_rdata_a (rf_a),
    .o_rdata_b (rf_b)
  );

  // Regfile read already carries the WB bypass, so only EX is layered on top.
  assign br_a = (i_ex_we && i_ex_addr != '0 && i_ex_addr == in_rs) ? i_ex_data : rf_a;
  assign br_b = (i_ex_we && i_ex_addr != '0 && i_ex_addr == in_rt) ? i_ex_data : rf_b;

  // Hazards against the instruction currently held in ID/EX
  assign ex_dest   = o_ctrl[CB_REG_DST] ? o_rd : o_rt;
  assign load_use  = o_valid && o_ctrl[CB_MEM_READ] && (o_rt != '0) &&
                     (o_rt == in_rs || o_rt == in_rt);
  assign br_hazard = (is_branch || is_jr) && o_valid && o_ctrl[CB_REG_WRITE] &&
                     (ex_dest != '0) && (ex_dest == in_rs || ex_dest == in_rt);
  assign hazard    = load_use || br_hazard;

  assign o_ready = (!o_valid || i_ready) && run && !hazard && !i_flush;
  assign accept  = i_valid && o_ready;

  assign imm_sext = {{(NB_DATA-16){i_instruction[15]}}, i_instruction[15:0]};
  assign imm_ext  = (in_op == OP_ANDI || in_op == OP_ORI || in_op == OP_XORI) ?
                    NB_DATA'(i_instruction[15:0]) : imm_sext;
  assign btarget  = i_pcounter4 + {imm_sext[NB_DATA-3:0], 2'b00};

  always_comb begin
    jtarget       = i_pcounter4;
    jtarget[27:0] = {i_instruction[25:0], 2'b00};
  end

  always_comb begin
    taken  = 1'b0;
    target = btarget;
    case (in_op)
      OP_BEQ:  taken = (br_a == br_b);
      OP_BNE:  taken = (br_a != br_b);
      OP_BLEZ: taken = br_a[NB_DATA-1] || (br_a == '0);
      OP_BGTZ: taken = !br_a[NB_DATA-1] && (br_a != '0);
      OP_J, OP_JAL: begin
        taken  = 1'b1;
        target = jtarget;
      end
      default: begin
        if (is_jr) begin
          taken  = 1'b1;
          target = br_a;
        end
      end
    endcase
  end

  // ID/EX register. An accepted HALT takes the "consumed" path so it never
  // becomes visible downstream.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_valid         <= 1'b0;
      o_rs            <= '0;
      o_rt            <= '0;
      o_rd            <= '0;
      o_reg_a         <= '0;
      o_reg_b         <= '0;
      o_immediate     <= '0;
      o_opcode        <= '0;
      o_func          <= '0;
      o_shamt         <= '0;
      o_ctrl          <= '0;
      o_redirect      <= 1'b0;
      o_redirect_addr <= '0;
    end else begin
      o_redirect <= 1'b0;
      if (i_flush) begin
        o_valid <= 1'b0;
      end else if (accept && !is_halt) begin
        o_valid     <= 1'b1;
        o_rs        <= in_rs;
        o_rt        <= in_rt;
        o_rd        <= (in_op == OP_JAL) ? NB_ADDR'(5'd31) : in_rd;
        o_reg_a     <= is_link ? i_pcounter4 : rf_a;
        o_reg_b     <= is_link ? '0 : rf_b;
        o_immediate <= imm_ext;
        o_opcode    <= in_op;
        o_func      <= in_fn;
        o_shamt     <= i_instruction[10:6];
        o_ctrl      <= NB_CTRL'(in_ctrl);
        o_redirect  <= taken;
        if (taken) o_redirect_addr <= target;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) state <= ST_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:    if (accept && is_halt) state_next = ST_DRAIN;
      ST_DRAIN:  if (!o_valid || i_ready) state_next = ST_HALTED;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  always_comb begin
    run      = 1'b0;
    o_halted = 1'b0;
    case (state)
      ST_RUN:    run = 1'b1;
      ST_HALTED: o_halted = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_decode_stage_hs.sv
module tb_decode_stage_hs;

  logic        clk;
  logic        i_rst, i_valid, o_ready, i_flush, i_ready;
  logic [31:0] i_instruction, i_pcounter4;
  logic        i_wb_we, i_ex_we;
  logic [4:0]  i_wb_addr, i_ex_addr;
  logic [31:0] i_wb_data, i_ex_data;
  logic        o_valid, o_redirect, o_halted;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [31:0] o_reg_a, o_reg_b, o_immediate, o_redirect_addr;
  logic [5:0]  o_opcode, o_func;
  logic [13:0] o_ctrl;

  decode_stage_hs #(
    .NB_DATA (32),
    .NB_REGS (32),
    .NB_ADDR (5),
    .NB_CTRL (14)
  ) dut (
    .clk             (clk),
    .i_rst           (i_rst),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_instruction   (i_instruction),
    .i_pcounter4     (i_pcounter4),
    .i_flush         (i_flush),
    .i_wb_we         (i_wb_we),
    .i_wb_addr       (i_wb_addr),
    .i_wb_data       (i_wb_data),
    .i_ex_we         (i_ex_we),
    .i_ex_addr       (i_ex_addr),
    .i_ex_data       (i_ex_data),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_rs            (o_rs),
    .o_rt            (o_rt),
    .o_rd            (o_rd),
    .o_reg_a         (o_reg_a),
    .o_reg_b         (o_reg_b),
    .o_immediate     (o_immediate),
    .o_opcode        (o_opcode),
    .o_func          (o_func),
    .o_shamt         (o_shamt),
    .o_ctrl          (o_ctrl),
    .o_redirect      (o_redirect),
    .o_redirect_addr (o_redirect_addr),
    .o_halted        (o_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] a, b, imm, raddr;
    logic [5:0]  op, fn;
    logic [13:0] ctrl;
    logic        redir;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Expected control bundles, hand-encoded from the bit layout
  localparam logic [13:0] C_RTYPE = 14'h0411;
  localparam logic [13:0] C_LW    = 14'h308B;
  localparam logic [13:0] C_BR    = 14'h0220;
  localparam logic [13:0] C_LINK  = 14'h0051;
  localparam logic [13:0] C_IMM   = 14'h0681;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] jtype(input int op, input int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc4);
    i_valid       = 1'b1;
    i_instruction = ins;
    i_pcounter4   = pc4;
  endtask

  task automatic push(input int rs, input int rt, input int rd, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm, input int op,
                      input int fn, input int sh, input logic [13:0] ctrl,
                      input logic redir, input logic [31:0] raddr);
    exp_t e;
    e.rs = 5'(rs); e.rt = 5'(rt); e.rd = 5'(rd); e.sh = 5'(sh);
    e.a = a; e.b = b; e.imm = imm; e.raddr = raddr;
    e.op = 6'(op); e.fn = 6'(fn); e.ctrl = ctrl; e.redir = redir;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb_empty: observed no expected entry, required one", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"},  32'(o_valid), 32'd1);
      chk({tag, "_rs"},     32'(o_rs), 32'(e.rs));
      chk({tag, "_rt"},     32'(o_rt), 32'(e.rt));
      chk({tag, "_rd"},     32'(o_rd), 32'(e.rd));
      chk({tag, "_reg_a"},  o_reg_a, e.a);
      chk({tag, "_reg_b"},  o_reg_b, e.b);
      chk({tag, "_imm"},    o_immediate, e.imm);
      chk({tag, "_opcode"}, 32'(o_opcode), 32'(e.op));
      chk({tag, "_func"},   32'(o_func), 32'(e.fn));
      chk({tag, "_shamt"},  32'(o_shamt), 32'(e.sh));
      chk({tag, "_ctrl"},   32'(o_ctrl), 32'(e.ctrl));
      chk({tag, "_redir"},  32'(o_redirect), 32'(e.redir));
      if (e.redir) chk({tag, "_raddr"}, o_redirect_addr, e.raddr);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    i_instruction = '0; i_pcounter4 = '0;
    i_wb_we = 1'b0; i_wb_addr = '0; i_wb_data = '0;
    i_ex_we = 1'b0; i_ex_addr = '0; i_ex_data = '0;
    tick();
    tick();
    chk("rst_valid",    32'(o_valid), 32'd0);
    chk("rst_halted",   32'(o_halted), 32'd0);
    chk("rst_redirect", 32'(o_redirect), 32'd0);
    chk("rst_reg_a",    o_reg_a, 32'd0);
    chk("rst_ctrl",     32'(o_ctrl), 32'd0);
    i_rst = 1'b0;
    settle();
    chk("rst_ready", 32'(o_ready), 32'd1);

    // Preload $1=3, $2=7
    i_wb_we = 1'b1; i_wb_addr = 5'd1; i_wb_data = 32'd3;
    tick();
    i_wb_addr = 5'd2; i_wb_data = 32'd7;
    tick();
    i_wb_we = 1'b0;

    // ADD $3,$5,$0 with same-cycle write-back of $5
    i_wb_we = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'h1234;
    drive(rtype(5, 0, 3, 0, 32'h20), 32'h4);
    push(5, 0, 3, 32'h1234, 32'h0, 32'h1820, 0, 32'h20, 0, C_RTYPE, 1'b0, 32'h0);
    settle();
    chk("t1_ready", 32'(o_ready), 32'd1);
    tick();
    i_wb_we = 1'b0; i_valid = 1'b0;
    pop_check("t1_add");

    // LW $2,0($1) then dependent ADD $4,$2,$1
    drive(itype(32'h23, 1, 2, 0), 32'h8);
    push(1, 2, 0, 32'd3, 32'd7, 32'h0, 32'h23, 0, 0, C_LW, 1'b0, 32'h0);
    tick();
    pop_check("t2_lw");
    drive(rtype(2, 1, 4, 0, 32'h20), 32'hC);
    settle();
    chk("t2_load_use_ready", 32'(o_ready), 32'd0);
    tick();
    chk("t2_lw_drained", 32'(o_valid), 32'd0);
    settle();
    chk("t2_load_use_clear", 32'(o_ready), 32'd1);
    push(2, 1, 4, 32'd7, 32'd3, 32'h2020, 0, 32'h20, 0, C_RTYPE, 1'b0, 32'h0);
    tick();
    pop_check("t2_add");
    // BEQ on $4 while ADD $4 sits in ID/EX
    drive(itype(4, 4, 0, 1), 32'h10);
    settle();
    chk("t2_branch_hazard", 32'(o_ready), 32'd0);
    i_valid = 1'b0;
    tick();
    chk("t2_add_drained", 32'(o_valid), 32'd0);

    // BEQ $1,$2,+3 with EX forwarding $1=7 -> taken
    i_ex_we = 1'b1; i_ex_addr = 5'd1; i_ex_data = 32'd7;
    drive(itype(4, 1, 2, 3), 32'h100);
    push(1, 2, 0, 32'd3, 32'd7, 32'd3, 4, 3, 0, C_BR, 1'b1, 32'h10C);
    tick();
    i_valid = 1'b0;
    pop_check("t3_beq_taken");
    tick();
    chk("t3_redirect_pulse", 32'(o_redirect), 32'd0);
    // Same branch with $2 written to 8 this cycle -> not taken
    i_wb_we = 1'b1; i_wb_addr = 5'd2; i_wb_data = 32'd8;
    drive(itype(4, 1, 2, 3), 32'h200);
    push(1, 2, 0, 32'd3, 32'd8, 32'd3, 4, 3, 0, C_BR, 1'b0, 32'h0);
    tick();
    i_valid = 1'b0;
    pop_check("t3_beq_not_taken");
    // BNE $1,$2: EX says $1=8, WB says $1=9; EX must win -> not taken
    i_ex_data = 32'd8;
    i_wb_addr = 5'd1; i_wb_data = 32'd9;
    drive(itype(5, 1, 2, 3), 32'h300);
    push(1, 2, 0, 32'd9, 32'd8, 32'd3, 5, 3, 0, C_BR, 1'b0, 32'h0);
    tick();
    i_valid = 1'b0; i_wb_we = 1'b0; i_ex_we = 1'b0;
    pop_check("t3_bne_ex_priority");

    // JAL 0x40 at pc4=0x20, then JALR $4,$1
    drive(jtype(3, 32'h40), 32'h20);
    push(0, 0, 31, 32'h20, 32'h0, 32'h40, 3, 0, 1, C_LINK, 1'b1, 32'h100);
    tick();
    i_valid = 1'b0;
    pop_check("t4_jal");
    drive(rtype(1, 0, 4, 0, 9), 32'h30);
    push(1, 0, 4, 32'h30, 32'h0, 32'h2009, 0, 9, 0, C_LINK, 1'b1, 32'd9);
    tick();
    i_valid = 1'b0;
    pop_check("t4_jalr");

    // ORI (zero-extended immediate), then back-pressure and flush
    drive(itype(32'h0D, 1, 6, 32'h8001), 32'h40);
    push(1, 6, 16, 32'd9, 32'h0, 32'h8001, 32'h0D, 1, 0, C_IMM, 1'b0, 32'h0);
    tick();
    pop_check("t5_ori");
    i_ready = 1'b0;
    drive(itype(8, 1, 7, 32'hFFFF), 32'h44);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_stall_valid", 32'(o_valid), 32'd1);
      chk("t5_stall_imm",   o_immediate, 32'h8001);
      chk("t5_stall_ready", 32'(o_ready), 32'd0);
    end
    i_flush = 1'b1;
    settle();
    chk("t5_flush_ready", 32'(o_ready), 32'd0);
    tick();
    chk("t5_flush_valid", 32'(o_valid), 32'd0);
    i_flush = 1'b0; i_ready = 1'b1;
    push(1, 7, 31, 32'd9, 32'h0, 32'hFFFF_FFFF, 8, 32'h3F, 32'h1F, C_IMM, 1'b0, 32'h0);
    tick();
    i_valid = 1'b0;
    pop_check("t5_addi");

    // HALT behind a stalled ID/EX entry
    i_ready = 1'b0;
    drive(32'hFFFF_FFFF, 32'h48);
    settle();
    chk("t6_halt_stall_ready", 32'(o_ready), 32'd0);
    tick();
    chk("t6_pending_valid", 32'(o_valid), 32'd1);
    chk("t6_not_halted",    32'(o_halted), 32'd0);
    i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("t6_drain_valid",  32'(o_valid), 32'd0);
    chk("t6_drain_ready",  32'(o_ready), 32'd0);
    chk("t6_drain_halted", 32'(o_halted), 32'd0);
    tick();
    chk("t6_halted",       32'(o_halted), 32'd1);
    chk("t6_halted_ready", 32'(o_ready), 32'd0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0; i_instruction = '0;
    settle();
    chk("t6_rst_halted", 32'(o_halted), 32'd0);
    chk("t6_rst_ready",  32'(o_ready), 32'd1);
    // Register file was cleared by reset
    drive(rtype(1, 2, 3, 0, 32'h20), 32'h50);
    push(1, 2, 3, 32'h0, 32'h0, 32'h1820, 0, 32'h20, 0, C_RTYPE, 1'b0, 32'h0);
    tick();
    i_valid = 1'b0;
    pop_check("t6_rf_cleared");
    // Reset while draining returns to RUN
    drive(32'hFFFF_FFFF, 32'h54);
    tick();
    i_valid = 1'b0;
    chk("t6_drain2_ready", 32'(o_ready), 32'd0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    settle();
    chk("t6_rst_drain_ready",  32'(o_ready), 32'd1);
    tick();
    chk("t6_rst_drain_halted", 32'(o_halted), 32'd0);

    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
